// File: rtl/div_seq_ctrl_pkg.sv
// div_ctrl_pkg: shared types and constants for the keypad division controller.
//   state_t      - controller FSM states
//   nibble_count - keys needed per operand for a given operand width
//   DIV_CYCLES   - quotient-bit iterations for the default operand width
package div_ctrl_pkg;

    typedef enum logic [2:0] {
        ENTRY_A,
        ENTRY_B,
        DIV,
        CONV,
        SHOW
    } state_t;

    localparam int unsigned DEF_W      = 8;
    localparam int unsigned DIV_CYCLES = DEF_W;

    function automatic int unsigned nibble_count(input int unsigned w);
        return w / 4;
    endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: keypad, BCD-converter handshake and result signals of the
// division controller.
//   master : keypad / bin2bcd side (drives keys, toggle, bcd_done)
//   slave  : controller side (drives bcd_start/bcd_bin, operands, results, status)
interface div_seq_ctrl_if #(
    parameter int unsigned W = 8
);

    logic         key_valid;
    logic [3:0]   key_hex;
    logic         sel_toggle;
    logic         bcd_done;
    logic         bcd_start;
    logic [W-1:0] bcd_bin;
    logic [W-1:0] a_val;
    logic [W-1:0] b_val;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_err;
    logic         show_rem;
    logic         result_valid;
    logic         busy;
    logic         key_drop;

    modport master (
        output key_valid, key_hex, sel_toggle, bcd_done,
        input  bcd_start, bcd_bin, a_val, b_val, quot, rem,
               div_err, show_rem, result_valid, busy, key_drop
    );

    modport slave (
        input  key_valid, key_hex, sel_toggle, bcd_done,
        output bcd_start, bcd_bin, a_val, b_val, quot, rem,
               div_err, show_rem, result_valid, busy, key_drop
    );

endinterface

// File: rtl/div_seq_ctrl_core.sv
// div_restoring_core: iterative unsigned restoring divider, one quotient bit
// per clock.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : load operands; iterations run on the following W cycles
//   dividend  : W-bit dividend, sampled on start
//   divisor   : W-bit divisor, sampled on start
//   busy      : iterating (or resolving a zero divisor)
//   done      : high during the final iteration; quot/rem valid that cycle
//   quot, rem : final results, valid only while done is high
//   div0      : divisor sampled as zero (quot=0, rem=dividend)
module div_restoring_core #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         div0
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    logic          busy_q, busy_d;
    logic          zero_q, zero_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  dvs_q, dvs_d;

    logic [W:0]    trial;
    logic          qbit;
    logic [W-1:0]  acc_step;
    logic [W-1:0]  sh_step;
    logic          last;

    // The shift register starts as the dividend and fills with quotient bits
    // from the LSB, so after W steps it holds the quotient.
    always_comb begin
        trial    = {acc_q, sh_q[W-1]};
        qbit     = (trial >= {1'b0, dvs_q});
        // The true difference is below the divisor, so W bits are enough.
        acc_step = qbit ? (trial[W-1:0] - dvs_q) : trial[W-1:0];
        sh_step  = {sh_q[W-2:0], qbit};
        last     = busy_q && (zero_q || (cnt_q == CW'(W - 1)));
    end

    always_comb begin
        busy_d = busy_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sh_d   = sh_q;
        dvs_d  = dvs_q;
        if (start) begin
            busy_d = 1'b1;
            zero_d = (divisor == '0);
            cnt_d  = '0;
            acc_d  = '0;
            sh_d   = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            acc_d = acc_step;
            sh_d  = sh_step;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            sh_q   <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sh_q   <= sh_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy = busy_q;
    assign done = last;
    assign div0 = zero_q;
    // With a zero divisor the shift register still holds the untouched dividend.
    assign quot = zero_q ? '0   : sh_step;
    assign rem  = zero_q ? sh_q : acc_step;

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences one keypad division transaction.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : div_seq_ctrl_if slave modport
//     key_valid/key_hex : key nibbles, MSB first; A then B, W/4 keys each
//     sel_toggle        : in SHOW, swap quotient/remainder view and reconvert
//     bcd_start/bcd_bin : one-cycle start pulse and value for bin2bcd
//     bcd_done          : bin2bcd completion pulse
//     a_val, b_val      : assembled operands
//     quot, rem, div_err: division results, divide-by-zero flag
//     show_rem          : 1 = remainder shown, 0 = quotient
//     result_valid      : BCD result stable (SHOW)
//     busy              : dividing or converting
//     key_drop          : key ignored this cycle
module div_seq_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               rst,
    div_seq_ctrl_if.slave      bus
);

    localparam int unsigned NK  = nibble_count(W);
    localparam int unsigned NKW = $clog2(NK + 1);

    state_t         state_q, state_d;
    logic [NKW-1:0] cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           err_q, err_d;
    logic           show_rem_q, show_rem_d;
    logic           bcd_start_q, bcd_start_d;
    logic [W-1:0]   bcd_bin_q, bcd_bin_d;
    logic           key_drop;

    logic           core_start;
    logic           core_busy;
    logic           core_done;
    logic [W-1:0]   core_quot;
    logic [W-1:0]   core_rem;
    logic           core_div0;

    function automatic logic [W-1:0] push_nib(input logic [W-1:0] v, input logic [3:0] k);
        logic [W-1:0] r;
        r      = v << 4;
        r[3:0] = k;
        return r;
    endfunction

    // Divisor comes from b_d so the core is started on the cycle the last
    // B nibble is accepted.
    div_restoring_core #(.W(W)) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .dividend (a_q),
        .divisor  (b_d),
        .busy     (core_busy),
        .done     (core_done),
        .quot     (core_quot),
        .rem      (core_rem),
        .div0     (core_div0)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        err_d       = err_q;
        show_rem_d  = show_rem_q;
        bcd_start_d = 1'b0;
        bcd_bin_d   = bcd_bin_q;
        core_start  = 1'b0;
        key_drop    = 1'b0;

        case (state_q)
            ENTRY_A: begin
                if (bus.key_valid) begin
                    a_d = push_nib(a_q, bus.key_hex);
                    if (cnt_q == NKW'(NK - 1)) begin
                        cnt_d   = '0;
                        state_d = ENTRY_B;
                    end else begin
                        cnt_d = cnt_q + NKW'(1);
                    end
                end
            end

            ENTRY_B: begin
                if (bus.key_valid) begin
                    b_d = push_nib(b_q, bus.key_hex);
                    if (cnt_q == NKW'(NK - 1)) begin
                        cnt_d      = '0;
                        err_d      = 1'b0;
                        core_start = 1'b1;
                        state_d    = DIV;
                    end else begin
                        cnt_d = cnt_q + NKW'(1);
                    end
                end
            end

            DIV: begin
                key_drop = bus.key_valid;
                if (core_done) begin
                    quot_d      = core_quot;
                    rem_d       = core_rem;
                    err_d       = core_div0;
                    bcd_bin_d   = show_rem_q ? core_rem : core_quot;
                    bcd_start_d = 1'b1;
                    state_d     = CONV;
                end else if (!core_busy) begin
                    state_d = ENTRY_A;
                end
            end

            CONV: begin
                key_drop = bus.key_valid;
                // A done coincident with our own start pulse is stale.
                if (bus.bcd_done && !bcd_start_q) begin
                    state_d = SHOW;
                end
            end

            SHOW: begin
                if (bus.key_valid) begin
                    a_d        = push_nib('0, bus.key_hex);
                    b_d        = '0;
                    quot_d     = '0;
                    rem_d      = '0;
                    err_d      = 1'b0;
                    show_rem_d = 1'b0;
                    if (NK == 1) begin
                        cnt_d   = '0;
                        state_d = ENTRY_B;
                    end else begin
                        cnt_d   = NKW'(1);
                        state_d = ENTRY_A;
                    end
                end else if (bus.sel_toggle) begin
                    show_rem_d  = ~show_rem_q;
                    bcd_bin_d   = show_rem_q ? quot_q : rem_q;
                    bcd_start_d = 1'b1;
                    state_d     = CONV;
                end
            end

            default: begin
                state_d = ENTRY_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ENTRY_A;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            show_rem_q  <= 1'b0;
            bcd_start_q <= 1'b0;
            bcd_bin_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            show_rem_q  <= show_rem_d;
            bcd_start_q <= bcd_start_d;
            bcd_bin_q   <= bcd_bin_d;
        end
    end

    assign bus.bcd_start    = bcd_start_q;
    assign bus.bcd_bin      = bcd_bin_q;
    assign bus.a_val        = a_q;
    assign bus.b_val        = b_q;
    assign bus.quot         = quot_q;
    assign bus.rem          = rem_q;
    assign bus.div_err      = err_q;
    assign bus.show_rem     = show_rem_q;
    assign bus.result_valid = (state_q == SHOW);
    assign bus.busy         = (state_q == DIV) || (state_q == CONV);
    assign bus.key_drop     = key_drop;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with W=8.
module tb_div_seq_ctrl;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [15:0] keys;   // A_hi, A_lo, B_hi, B_lo nibbles
        logic [7:0]  q;
        logic [7:0]  r;
        logic        err;
        logic [7:0]  lat;    // edges from last key to bcd_start cycle
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_pass = 0;
    int   n_tot  = 0;

    div_seq_ctrl_if #(.W(W)) bus();

    div_seq_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_hex   = k;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_start(input int n0, output int n);
        n = n0;
        while (!bus.bcd_start && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic finish_conv();
        tick();
        bus.bcd_done = 1'b1;
        tick();
        bus.bcd_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   n;
        int   starts;

        vecs[0] = '{keys: 16'h6407, q: 8'h0E, r: 8'h02, err: 1'b0, lat: 8'd9};
        vecs[1] = '{keys: 16'hFF00, q: 8'h00, r: 8'hFF, err: 1'b1, lat: 8'd2};
        vecs[2] = '{keys: 16'hFF01, q: 8'hFF, r: 8'h00, err: 1'b0, lat: 8'd9};
        vecs[3] = '{keys: 16'h0305, q: 8'h00, r: 8'h03, err: 1'b0, lat: 8'd9};
        vecs[4] = '{keys: 16'hFFFF, q: 8'h01, r: 8'h00, err: 1'b0, lat: 8'd9};
        vecs[5] = '{keys: 16'h8003, q: 8'h2A, r: 8'h02, err: 1'b0, lat: 8'd9};
        vecs[6] = '{keys: 16'h0007, q: 8'h00, r: 8'h00, err: 1'b0, lat: 8'd9};

        rst            = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_hex    = 4'h0;
        bus.sel_toggle = 1'b0;
        bus.bcd_done   = 1'b0;
        repeat (3) tick();
        chk("reset_result_valid", bus.result_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_a_val", bus.a_val, 0);
        chk("reset_bcd_start", bus.bcd_start, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Table: full transactions, first from reset, then chained from SHOW.
        for (int i = 0; i < 7; i++) begin
            logic [15:0] k;
            k = vecs[i].keys;
            press(k[15:12]);
            press(k[11:8]);
            press(k[7:4]);
            press(k[3:0]);
            chk("div_busy", bus.busy, 1);
            chk("div_result_valid", bus.result_valid, 0);
            wait_start(1, n);
            chk("latency", n, vecs[i].lat);
            chk("quot", bus.quot, vecs[i].q);
            chk("rem", bus.rem, vecs[i].r);
            chk("div_err", bus.div_err, vecs[i].err);
            chk("a_val", bus.a_val, k[15:8]);
            chk("b_val", bus.b_val, k[7:0]);
            chk("bcd_bin", bus.bcd_bin, vecs[i].q);
            chk("show_rem", bus.show_rem, 0);
            tick();
            chk("bcd_start_one_cycle", bus.bcd_start, 0);
            bus.bcd_done = 1'b1;
            tick();
            bus.bcd_done = 1'b0;
            chk("show_result_valid", bus.result_valid, 1);
            chk("show_busy", bus.busy, 0);
        end

        // Quotient/remainder toggle with reconversion.
        press(4'h6);
        chk("first_key_a_val", bus.a_val, 8'h06);
        chk("first_key_b_val", bus.b_val, 0);
        chk("first_key_quot", bus.quot, 0);
        chk("first_key_err", bus.div_err, 0);
        press(4'h4); press(4'h0); press(4'h7);
        wait_start(1, n);
        chk("tog_latency", n, 9);
        finish_conv();
        bus.sel_toggle = 1'b1;
        tick();
        bus.sel_toggle = 1'b0;
        chk("tog_bcd_start", bus.bcd_start, 1);
        chk("tog_show_rem", bus.show_rem, 1);
        chk("tog_bcd_bin", bus.bcd_bin, 8'h02);
        chk("tog_result_valid", bus.result_valid, 0);
        bus.bcd_done = 1'b1;               // coincident with bcd_start: ignored
        tick();
        bus.bcd_done = 1'b0;
        chk("early_done_ignored", bus.result_valid, 0);
        chk("early_done_busy", bus.busy, 1);
        bus.sel_toggle = 1'b1;             // outside SHOW: ignored
        tick();
        bus.sel_toggle = 1'b0;
        chk("conv_toggle_ignored", bus.show_rem, 1);
        chk("conv_no_restart", bus.bcd_start, 0);
        chk("conv_result_valid", bus.result_valid, 0);
        bus.bcd_done = 1'b1;
        tick();
        bus.bcd_done = 1'b0;
        chk("tog_done_valid", bus.result_valid, 1);
        bus.sel_toggle = 1'b1;
        tick();
        bus.sel_toggle = 1'b0;
        chk("tog_back_show_rem", bus.show_rem, 0);
        chk("tog_back_bcd_bin", bus.bcd_bin, 8'h0E);
        chk("tog_back_bcd_start", bus.bcd_start, 1);
        finish_conv();
        chk("tog_back_valid", bus.result_valid, 1);

        // Keys during DIV and CONV are dropped.
        press(4'h6); press(4'h4); press(4'h0); press(4'h7);
        bus.key_valid = 1'b1;
        bus.key_hex   = 4'h9;
        #1;
        chk("drop_div", bus.key_drop, 1);
        tick();
        bus.key_valid = 1'b0;
        #1;
        chk("drop_div_pulse_end", bus.key_drop, 0);
        chk("drop_div_a_val", bus.a_val, 8'h64);
        chk("drop_div_b_val", bus.b_val, 8'h07);
        wait_start(2, n);
        chk("drop_latency", n, 9);
        chk("drop_quot", bus.quot, 8'h0E);
        tick();
        bus.key_valid = 1'b1;
        bus.key_hex   = 4'h3;
        #1;
        chk("drop_conv", bus.key_drop, 1);
        tick();
        bus.key_valid = 1'b0;
        chk("drop_conv_a_val", bus.a_val, 8'h64);
        chk("drop_conv_b_val", bus.b_val, 8'h07);
        chk("drop_conv_rem", bus.rem, 8'h02);
        chk("drop_conv_valid", bus.result_valid, 0);
        bus.bcd_done = 1'b1;
        tick();
        bus.bcd_done = 1'b0;
        chk("drop_done_valid", bus.result_valid, 1);

        // Key and toggle together in SHOW: key wins.
        bus.key_valid  = 1'b1;
        bus.sel_toggle = 1'b1;
        bus.key_hex    = 4'h5;
        #1;
        chk("show_key_no_drop", bus.key_drop, 0);
        tick();
        bus.key_valid  = 1'b0;
        bus.sel_toggle = 1'b0;
        chk("kw_show_rem", bus.show_rem, 0);
        chk("kw_result_valid", bus.result_valid, 0);
        chk("kw_busy", bus.busy, 0);
        chk("kw_bcd_start", bus.bcd_start, 0);
        chk("kw_a_val", bus.a_val, 8'h05);
        chk("kw_quot", bus.quot, 0);

        // Reset in DIV cycle 4.
        press(4'h4); press(4'h0); press(4'h7);
        tick(); tick(); tick();
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b0;
        #1;
        chk("rst_a_val", bus.a_val, 0);
        chk("rst_b_val", bus.b_val, 0);
        chk("rst_quot", bus.quot, 0);
        chk("rst_rem", bus.rem, 0);
        chk("rst_div_err", bus.div_err, 0);
        chk("rst_show_rem", bus.show_rem, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bcd_start", bus.bcd_start, 0);
        chk("rst_bcd_bin", bus.bcd_bin, 0);
        chk("rst_key_drop", bus.key_drop, 0);
        @(negedge clk);
        rst = 1'b1;
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.bcd_start) starts++;
        end
        chk("post_rst_no_start", starts, 0);
        chk("post_rst_busy", bus.busy, 0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("post_rst_a_val", bus.a_val, 8'h12);
        chk("post_rst_b_val", bus.b_val, 8'h34);
        chk("post_rst_div", bus.busy, 1);
        wait_start(1, n);
        chk("post_rst_latency", n, 9);
        chk("post_rst_quot", bus.quot, 8'h00);
        chk("post_rst_rem", bus.rem, 8'h12);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Controller that sequences one keypad division transaction from key entry to display.
- Assembles dividend A and divisor B from hex key nibbles.
- Runs an iterative restoring shift-subtract division, one quotient bit per clock.
- Handles divide-by-zero.
- Starts the binary-to-BCD converter through a start/done handshake and holds the result for the 7-segment display path.
- Lets the user toggle between showing the quotient and the remainder, reconverting on each toggle.

Parameters:
W, 8, operand width in bits; must be a multiple of 4; keys per operand = W/4.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle pulse, key_hex valid
key_hex  in  4  key nibble, MSB-first entry
sel_toggle  in  1  one-cycle pulse; swaps quotient/remainder view
bcd_done  in  1  one-cycle pulse from bin2bcd, conversion complete
bcd_start  out  1  one-cycle pulse, starts bin2bcd
bcd_bin  out  W  value to convert (registered)
a_val  out  W  assembled dividend
b_val  out  W  assembled divisor
quot  out  W  quotient
rem  out  W  remainder
div_err  out  1  divisor was zero
show_rem  out  1  1 = remainder displayed, 0 = quotient
result_valid  out  1  BCD result stable and displayable
busy  out  1  high in DIV or CONV
key_drop  out  1  one-cycle pulse, key ignored

Behaviour:
Reset (async, rst=0): all outputs 0; state ENTRY_A with nibble count 0; internal datapath registers 0.

States:
- ENTRY_A: each key_valid shifts key_hex into a_val from the LSB end (a_val <= {a_val[W-5:0], key_hex}). After W/4 keys go to ENTRY_B.
- ENTRY_B: same shifting, into b_val. On the accepting cycle of the last nibble go to DIV.
- DIV:
  - On entry, load remainder accumulator = 0 and shift register = a_val.
  - Each cycle: accumulator <= {acc[W-2:0], msb of shift register}; if that value >= b_val, subtract b_val and shift in quotient bit 1, else 0.
  - Exactly W cycles. On the last cycle, quot and rem register the final values; next state CONV.
  - If b_val == 0: the DIV state lasts 1 cycle; quot=0, rem=a_val, div_err=1.
  - Otherwise div_err is cleared on DIV entry.
- CONV:
  - First cycle: bcd_bin <= show_rem ? rem : quot; bcd_start=1 for exactly that cycle.
  - Then wait for bcd_done; on bcd_done go to SHOW.
  - result_valid=0 throughout CONV.
- SHOW: result_valid=1.
  - sel_toggle: show_rem <= ~show_rem, go to CONV (reconvert).
  - key_valid: clear a_val, b_val, quot, rem, div_err and show_rem; load key_hex as the first A nibble; go to ENTRY_A with count 1.

Rules and boundary conditions:
- busy = state in {DIV, CONV}.
- key_valid during DIV/CONV: ignored, key_drop=1 that cycle.
- sel_toggle outside SHOW: ignored (no key_drop).
- key_valid and sel_toggle together in SHOW: key wins, toggle discarded.
- bcd_done outside CONV: ignored.
- bcd_done in the same cycle as bcd_start: accepted only from the cycle after bcd_start.
- Latency, non-zero divisor: last B key accepted at cycle t → quot/rem valid at t+W+1 → bcd_start at t+W+1 (CONV first cycle) → result_valid the cycle after bcd_done.
- Arithmetic is unsigned, W bits, no overflow possible. Quotient 0..2^W-1, remainder < b_val.
- Reset mid-operation aborts immediately; no pending bcd_start is issued after reset deassertion.

Decomposition:
- Package div_ctrl_pkg:
  - typedef enum state_t {ENTRY_A, ENTRY_B, DIV, CONV, SHOW};
  - localparam function computing nibble count W/4;
  - localparam DIV_CYCLES = W.
- Sub-module div_restoring_core (W): the iterative datapath with start, busy, done, dividend, divisor, quot, rem, div0.
- The FSM, key assembly and BCD handshake stay in div_seq_ctrl.

Test Plan:
- Keys 6,4,0,7 (A=0x64, B=0x07):
  - quot=0x0E, rem=0x02, div_err=0;
  - bcd_start exactly 9 cycles after the last key, bcd_bin=0x0E.
- After SHOW, pulse sel_toggle:
  - show_rem=1, new bcd_start with bcd_bin=0x02;
  - result_valid low until bcd_done, then high.
- Keys F,F,0,0:
  - div_err=1, quot=0x00, rem=0xFF;
  - bcd_start 2 cycles after the last key.
- Keys F,F,0,1 → quot=0xFF, rem=0x00. Keys 0,3,0,5 → quot=0x00, rem=0x03.
- Key pulses during DIV and while waiting for bcd_done:
  - key_drop pulses each time;
  - a_val, b_val and results unchanged.
- rst low during DIV (cycle 4):
  - all outputs 0 immediately, state ENTRY_A;
  - no bcd_start over the next 20 cycles.
